// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with saturating direction
// counters plus a circular return address stack, trained at resolution.
package common;
  typedef enum logic [1:0] {
    NOT_BRANCH = 2'd0,
    PC_JMP     = 2'd1,
    COND_BR    = 2'd2,
    REG_JMP    = 2'd3
  } branch_type_t;
endpackage

module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int CNT_WIDTH = 2,
  parameter int RAS_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_pred_pc,
  output logic                 o_pred_taken,
  output logic [31:0]          o_pred_target,
  input  logic                 i_upd_valid,
  input  logic [31:0]          i_upd_pc,
  input  common::branch_type_t i_upd_type,
  input  logic                 i_upd_taken,
  input  logic [31:0]          i_upd_target,
  input  logic [4:0]           i_upd_rd,
  input  logic [4:0]           i_upd_rs1
);
  import common::*;

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC_W  = $clog2(RAS_DEPTH + 1);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_WNT  = CNT_MAX >> 1;
  localparam logic [CNT_WIDTH-1:0] CNT_WT   = ~CNT_WNT;
  localparam logic [PTR_W-1:0]     PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [RC_W-1:0]      RC_ZERO  = {RC_W{1'b0}};
  localparam logic [RC_W-1:0]      RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]      RC_FULL  = RC_W'(RAS_DEPTH);

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? PTR_ZERO : p + PTR_ONE;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == PTR_ZERO) ? PTR_LAST : p - PTR_ONE;
  endfunction

  logic                 r_valid  [ENTRIES];
  logic [TAG_W-1:0]     r_tag    [ENTRIES];
  branch_type_t         r_type   [ENTRIES];
  logic                 r_is_ret [ENTRIES];
  logic [31:0]          r_target [ENTRIES];
  logic [CNT_WIDTH-1:0] r_cnt    [ENTRIES];
  logic [31:0]          r_ras    [RAS_DEPTH];
  logic [PTR_W-1:0]     r_top;
  logic [RC_W-1:0]      r_count;

  logic [IDX_W-1:0]     w_pidx, w_uidx;
  logic [TAG_W-1:0]     w_ptag, w_utag;
  logic                 w_phit, w_utag_match, w_uhit;
  logic                 w_is_ret_d, w_ras_push, w_ras_pop;
  logic                 w_we_valid, w_valid_d, w_we_meta, w_we_tgt, w_we_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_d;
  logic [PTR_W-1:0]     w_top_pop, w_top_d;
  logic [RC_W-1:0]      w_cnt_pop, w_count_d;

  assign w_pidx       = i_pred_pc[IDX_W+1:2];
  assign w_ptag       = i_pred_pc[31:IDX_W+2];
  assign w_uidx       = i_upd_pc[IDX_W+1:2];
  assign w_utag       = i_upd_pc[31:IDX_W+2];
  assign w_phit       = r_valid[w_pidx] && (r_tag[w_pidx] == w_ptag);
  assign w_utag_match = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_uhit       = w_utag_match && (r_type[w_uidx] == i_upd_type);
  assign w_is_ret_d   = (i_upd_type == REG_JMP) && is_link(i_upd_rs1) && !is_link(i_upd_rd);
  // Link rd with a different link rs1 (jalr x1, x5) both pops and pushes.
  assign w_ras_push   = i_upd_valid && ((i_upd_type == PC_JMP) || (i_upd_type == REG_JMP))
                        && is_link(i_upd_rd);
  assign w_ras_pop    = i_upd_valid && (i_upd_type == REG_JMP) && is_link(i_upd_rs1)
                        && (!is_link(i_upd_rd) || (i_upd_rd != i_upd_rs1));

  // Combinational prediction from the fetch PC and current state.
  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_target = i_pred_pc + 32'd4;
    if (w_phit) begin
      case (r_type[w_pidx])
        PC_JMP: begin
          o_pred_taken  = 1'b1;
          o_pred_target = r_target[w_pidx];
        end
        COND_BR: begin
          if (r_cnt[w_pidx][CNT_WIDTH-1]) begin
            o_pred_taken  = 1'b1;
            o_pred_target = r_target[w_pidx];
          end else begin
            o_pred_taken  = 1'b0;
            o_pred_target = i_pred_pc + 32'd4;
          end
        end
        REG_JMP: begin
          o_pred_taken = 1'b1;
          if (r_is_ret[w_pidx] && (r_count != RC_ZERO)) begin
            o_pred_target = r_ras[r_top];
          end else begin
            o_pred_target = r_target[w_pidx];
          end
        end
        default: begin
          o_pred_taken  = 1'b0;
          o_pred_target = i_pred_pc + 32'd4;
        end
      endcase
    end else begin
      o_pred_taken  = 1'b0;
      o_pred_target = i_pred_pc + 32'd4;
    end
  end

  // BTB training decode: which fields of the indexed entry change.
  always_comb begin
    w_we_valid = 1'b0;
    w_valid_d  = 1'b0;
    w_we_meta  = 1'b0;
    w_we_tgt   = 1'b0;
    w_we_cnt   = 1'b0;
    w_cnt_d    = r_cnt[w_uidx];
    if (i_upd_valid) begin
      case (i_upd_type)
        NOT_BRANCH: begin
          if (w_utag_match) begin
            w_we_valid = 1'b1;
            w_valid_d  = 1'b0;
          end else begin
            w_we_valid = 1'b0;
          end
        end
        PC_JMP, REG_JMP: begin
          w_we_valid = 1'b1;
          w_valid_d  = 1'b1;
          w_we_meta  = 1'b1;
          w_we_tgt   = 1'b1;
        end
        COND_BR: begin
          if (w_uhit) begin
            w_we_cnt = 1'b1;
            if (i_upd_taken) begin
              w_cnt_d  = (r_cnt[w_uidx] == CNT_MAX) ? CNT_MAX : r_cnt[w_uidx] + CNT_ONE;
              w_we_tgt = 1'b1;
            end else begin
              w_cnt_d  = (r_cnt[w_uidx] == CNT_ZERO) ? CNT_ZERO : r_cnt[w_uidx] - CNT_ONE;
            end
          end else if (i_upd_taken) begin
            w_we_valid = 1'b1;
            w_valid_d  = 1'b1;
            w_we_meta  = 1'b1;
            w_we_tgt   = 1'b1;
            w_we_cnt   = 1'b1;
            w_cnt_d    = CNT_WT;
          end else begin
            w_we_cnt = 1'b0;
          end
        end
        default: begin
          w_we_valid = 1'b0;
        end
      endcase
    end else begin
      w_we_valid = 1'b0;
    end
  end

  // RAS next pointer/count: optional pop first, then optional push.
  always_comb begin
    w_top_pop = r_top;
    w_cnt_pop = r_count;
    if (w_ras_pop && (r_count != RC_ZERO)) begin
      w_top_pop = ptr_dec(r_top);
      w_cnt_pop = r_count - RC_ONE;
    end else begin
      w_top_pop = r_top;
      w_cnt_pop = r_count;
    end
    w_top_d   = w_top_pop;
    w_count_d = w_cnt_pop;
    if (w_ras_push) begin
      w_top_d   = ptr_inc(w_top_pop);
      w_count_d = (w_cnt_pop == RC_FULL) ? RC_FULL : w_cnt_pop + RC_ONE;
    end else begin
      w_top_d   = w_top_pop;
      w_count_d = w_cnt_pop;
    end
  end

  // Reset-bearing state: entry valid bits, direction counters, RAS pointers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_WNT;
      end
      r_top   <= PTR_ZERO;
      r_count <= RC_ZERO;
    end else begin
      if (w_we_valid) r_valid[w_uidx] <= w_valid_d;
      if (w_we_cnt)   r_cnt[w_uidx]   <= w_cnt_d;
      r_top   <= w_top_d;
      r_count <= w_count_d;
    end
  end

  // Payload storage; meaningful only under a set valid bit or nonzero count.
  always_ff @(posedge i_clk) begin
    if (w_we_meta) begin
      r_tag[w_uidx]    <= w_utag;
      r_type[w_uidx]   <= i_upd_type;
      r_is_ret[w_uidx] <= w_is_ret_d;
    end
    if (w_we_tgt) r_target[w_uidx] <= i_upd_target;
    if (w_ras_push) r_ras[w_top_d] <= i_upd_pc + 32'd4;
  end

endmodule
